spi_req_arbiter: RTL and testbench

- Round-robin controller that shares one SPI master between two requesters (req0, req1).
- Accepts 16-bit transmit words, drives the master's user interface (spi_en, spi_mode, spi_sdata), waits for spi_done, and returns the received word to the requester that owns the frame.
- Each requester has a fixed SPI mode.
- A watchdog aborts frames that never complete.

---
 rtl/spi_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Each requester has a fixed SPI mode. A watchdog aborts frames that never see spi_done.
module spi_req_arbiter #(
    parameter logic [1:0]  MODE_REQ0   = 2'd1,
    parameter logic [1:0]  MODE_REQ1   = 2'd3,
    parameter logic [7:0]  GAP_CYC     = 8'd60,
    parameter logic [15:0] TIMEOUT_CYC = 16'd2000
) (
    input  logic        i_sys_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    input  logic [15:0] i_req0_data,
    output logic        o_req0_ready,
    output logic        o_rsp0_valid,
    output logic [15:0] o_rsp0_data,
    output logic        o_rsp0_err,
    input  logic        i_req1_valid,
    input  logic [15:0] i_req1_data,
    output logic        o_req1_ready,
    output logic        o_rsp1_valid,
    output logic [15:0] o_rsp1_data,
    output logic        o_rsp1_err,
    output logic        o_spi_en,
    output logic [1:0]  o_spi_mode,
    output logic [15:0] o_spi_sdata,
    input  logic [15:0] i_spi_rdata,
    input  logic        i_spi_done,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rr;
    logic        r_owner;
    logic [15:0] r_wdog;
    logic [7:0]  r_gap;
    logic        r_spi_en;
    logic [1:0]  r_spi_mode;
    logic [15:0] r_spi_sdata;
    logic        r_rsp0_valid;
    logic        r_rsp0_err;
    logic [15:0] r_rsp0_data;
    logic        r_rsp1_valid;
    logic        r_rsp1_err;
    logic [15:0] r_rsp1_data;

    logic        w_any_req;
    logic        w_winner;
    logic        w_done_hit;
    logic        w_timeout;
    logic        w_gap_end;

    // rr=0 favours req0; fall back to the other requester when the favoured one is idle.
    assign w_any_req  = i_req0_valid | i_req1_valid;
    assign w_winner   = r_rr ? i_req1_valid : ~i_req0_valid;
    assign w_done_hit = (r_state == S_BUSY) && i_spi_done;
    assign w_timeout  = (r_state == S_BUSY) && !i_spi_done && (r_wdog == TIMEOUT_CYC - 16'd1);
    assign w_gap_end  = (r_gap == GAP_CYC - 8'd1);

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_GRANT;
            S_GRANT: w_next_state = S_BUSY;
            S_BUSY:  if (w_done_hit || w_timeout) w_next_state = S_GAP;
            S_GAP:   if (w_gap_end) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_req0_ready = (r_state == S_GRANT) && !r_owner;
        o_req1_ready = (r_state == S_GRANT) && r_owner;
        o_busy       = (r_state != S_IDLE);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr         <= 1'b0;
            r_owner      <= 1'b0;
            r_wdog       <= 16'd0;
            r_gap        <= 8'd0;
            r_spi_en     <= 1'b0;
            r_spi_mode   <= MODE_REQ0;
            r_spi_sdata  <= 16'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_err   <= 1'b0;
            r_rsp0_data  <= 16'd0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_err   <= 1'b0;
            r_rsp1_data  <= 16'd0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) r_owner <= w_winner;
                end
                S_GRANT: begin
                    r_spi_sdata <= r_owner ? i_req1_data : i_req0_data;
                    r_spi_mode  <= r_owner ? MODE_REQ1 : MODE_REQ0;
                    r_rr        <= ~r_owner;
                    r_spi_en    <= 1'b1;
                    r_wdog      <= 16'd0;
                end
                S_BUSY: begin
                    r_wdog <= r_wdog + 16'd1;
                    // A done in the last watchdog cycle still counts as a normal completion.
                    if (w_done_hit) begin
                        r_spi_en <= 1'b0;
                        r_gap    <= 8'd0;
                        if (r_owner) begin
                            r_rsp1_valid <= 1'b1;
                            r_rsp1_data  <= i_spi_rdata;
                        end else begin
                            r_rsp0_valid <= 1'b1;
                            r_rsp0_data  <= i_spi_rdata;
                        end
                    end else if (w_timeout) begin
                        r_spi_en <= 1'b0;
                        r_gap    <= 8'd0;
                        if (r_owner) begin
                            r_rsp1_valid <= 1'b1;
                            r_rsp1_err   <= 1'b1;
                            r_rsp1_data  <= 16'd0;
                        end else begin
                            r_rsp0_valid <= 1'b1;
                            r_rsp0_err   <= 1'b1;
                            r_rsp0_data  <= 16'd0;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + 8'd1;
                end
                default: begin
                    r_gap <= 8'd0;
                end
            endcase
        end
    end

    assign o_spi_en     = r_spi_en;
    assign o_spi_mode   = r_spi_mode;
    assign o_spi_sdata  = r_spi_sdata;
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp0_err   = r_rsp0_err;
    assign o_rsp0_data  = r_rsp0_data;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp1_err   = r_rsp1_err;
    assign o_rsp1_data  = r_rsp1_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a small SPI master model answers frames after a set delay,
// and all activity happens on the falling clock edge so DUT outputs are stable when sampled.
module tb_spi_req_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req0Valid, req1Valid;
    logic [15:0] req0Data, req1Data;
    logic        req0Ready, req1Ready;
    logic        rsp0Valid, rsp1Valid;
    logic [15:0] rsp0Data, rsp1Data;
    logic        rsp0Err, rsp1Err;
    logic        spiEn;
    logic [1:0]  spiMode;
    logic [15:0] spiSdata;
    logic [15:0] spiRdata;
    logic        spiDone;
    logic        busy;

    int   checkCount = 0;
    int   errorCount = 0;
    int   doneDelay  = 0;
    int   enCount    = 0;
    logic modelDone  = 1'b0;
    logic forceDone  = 1'b0;

    int          who, cyc, n0, n1;
    logic        sawRsp, sawEn;
    logic [15:0] d0, d1;

    spi_req_arbiter dut (
        .i_sys_clk    (clk),
        .i_rst_n      (rstN),
        .i_req0_valid (req0Valid),
        .i_req0_data  (req0Data),
        .o_req0_ready (req0Ready),
        .o_rsp0_valid (rsp0Valid),
        .o_rsp0_data  (rsp0Data),
        .o_rsp0_err   (rsp0Err),
        .i_req1_valid (req1Valid),
        .i_req1_data  (req1Data),
        .o_req1_ready (req1Ready),
        .o_rsp1_valid (rsp1Valid),
        .o_rsp1_data  (rsp1Data),
        .o_rsp1_err   (rsp1Err),
        .o_spi_en     (spiEn),
        .o_spi_mode   (spiMode),
        .o_spi_sdata  (spiSdata),
        .i_spi_rdata  (spiRdata),
        .i_spi_done   (spiDone),
        .o_busy       (busy)
    );

    always #10 clk = ~clk;

    // Master model: pulses done when spi_en has been seen high for doneDelay falling edges (0 = never).
    always @(negedge clk) begin
        if (!rstN) begin
            enCount   = 0;
            modelDone = 1'b0;
        end else begin
            modelDone = 1'b0;
            if (spiEn) begin
                enCount = enCount + 1;
                if (doneDelay != 0 && enCount == doneDelay) modelDone = 1'b1;
            end else begin
                enCount = 0;
            end
        end
    end

    assign spiDone = modelDone | forceDone;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [15:0] dat0, input logic v1, input logic [15:0] dat1);
        req0Valid = v0;
        req0Data  = dat0;
        req1Valid = v1;
        req1Data  = dat1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitGrant(output int winner);
        winner = -1;
        for (int i = 0; i < 300 && winner < 0; i++) begin
            tick(1);
            if (req0Ready || req1Ready) begin
                checkOutput("oneReady", {31'd0, req0Ready & req1Ready}, 32'd0);
                winner = req1Ready ? 1 : 0;
            end
        end
    endtask

    task automatic waitRsp(input int which, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit && cycles < 0; i++) begin
            tick(1);
            if (rsp0Valid || rsp1Valid) begin
                cycles = i;
                checkOutput("rspRoute", {30'd0, rsp1Valid, rsp0Valid}, (which == 0) ? 32'd1 : 32'd2);
            end
        end
    endtask

    task automatic waitIdle(input int spurAt, output int cycles, output logic anyRsp, output logic anyEn);
        cycles = -1;
        anyRsp = 1'b0;
        anyEn  = 1'b0;
        for (int i = 0; i < 300 && cycles < 0; i++) begin
            forceDone = (i == spurAt);
            tick(1);
            if (rsp0Valid || rsp1Valid) anyRsp = 1'b1;
            if (spiEn) anyEn = 1'b1;
            if (!busy) cycles = i + 1;
        end
        forceDone = 1'b0;
    endtask

    initial begin
        rstN     = 1'b0;
        spiRdata = 16'h0000;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        tick(2);

        $display("[TB] reset values");
        checkOutput("rst.spiEn", spiEn, 32'd0);
        checkOutput("rst.spiMode", spiMode, 32'd1);
        checkOutput("rst.spiSdata", spiSdata, 32'd0);
        checkOutput("rst.busy", busy, 32'd0);
        checkOutput("rst.ready", {req1Ready, req0Ready}, 32'd0);
        checkOutput("rst.rspValid", {rsp1Valid, rsp0Valid}, 32'd0);
        checkOutput("rst.rspErr", {rsp1Err, rsp0Err}, 32'd0);
        checkOutput("rst.rspData", {rsp1Data, rsp0Data}, 32'd0);

        $display("[TB] single request on req0");
        doneDelay = 900;
        spiRdata  = 16'h1234;
        applyStimulus(1'b1, 16'hA55A, 1'b0, 16'h0000);
        rstN = 1'b1;
        waitGrant(who);
        checkOutput("single.grant", who, 32'd0);
        tick(1);
        applyStimulus(1'b0, 16'hA55A, 1'b0, 16'h0000);
        checkOutput("single.readyPulse", req0Ready, 32'd0);
        checkOutput("single.spiEn", spiEn, 32'd1);
        checkOutput("single.mode", spiMode, 32'd1);
        checkOutput("single.sdata", spiSdata, 32'hA55A);
        waitRsp(0, 1500, cyc);
        checkOutput("single.latency", cyc, 32'd900);
        checkOutput("single.rspData", rsp0Data, 32'h1234);
        checkOutput("single.rspErr", rsp0Err, 32'd0);
        checkOutput("single.enDropped", spiEn, 32'd0);
        // A stray done in the middle of the gap must be ignored.
        waitIdle(10, cyc, sawRsp, sawEn);
        checkOutput("single.gapLen", cyc, 32'd60);
        checkOutput("single.gapNoRsp", sawRsp, 32'd0);
        checkOutput("single.gapNoEn", sawEn, 32'd0);
        forceDone = 1'b1;
        tick(1);
        forceDone = 1'b0;
        tick(1);
        checkOutput("spurIdle.busy", busy, 32'd0);
        checkOutput("spurIdle.rsp", {rsp1Valid, rsp0Valid}, 32'd0);
        checkOutput("spurIdle.spiEn", spiEn, 32'd0);

        $display("[TB] contention, three frames each");
        rstN      = 1'b0;
        doneDelay = 10;
        d0 = 16'h0100;
        d1 = 16'h0200;
        n0 = 0;
        n1 = 0;
        applyStimulus(1'b1, d0, 1'b1, d1);
        tick(2);
        rstN = 1'b1;
        for (int f = 0; f < 6; f++) begin
            waitGrant(who);
            checkOutput($sformatf("cont%0d.grant", f), who, f % 2);
            spiRdata = 16'hC000 + 16'(f);
            tick(1);
            checkOutput($sformatf("cont%0d.mode", f), spiMode, (f % 2 == 0) ? 32'd1 : 32'd3);
            checkOutput($sformatf("cont%0d.sdata", f), spiSdata, (f % 2 == 0) ? {16'd0, d0} : {16'd0, d1});
            if (f % 2 == 0) begin
                n0++;
                d0 = d0 + 16'd1;
            end else begin
                n1++;
                d1 = d1 + 16'd1;
            end
            applyStimulus(n0 < 3, d0, n1 < 3, d1);
            waitRsp(f % 2, 100, cyc);
            checkOutput($sformatf("cont%0d.latency", f), cyc, 32'd10);
            checkOutput($sformatf("cont%0d.rspData", f), (f % 2 == 0) ? rsp0Data : rsp1Data, 32'hC000 + f);
            checkOutput($sformatf("cont%0d.rspErr", f), {rsp1Err, rsp0Err}, 32'd0);
        end
        checkOutput("cont.hold0", rsp0Data, 32'hC004);
        checkOutput("cont.hold1", rsp1Data, 32'hC005);
        waitIdle(-1, cyc, sawRsp, sawEn);
        checkOutput("cont.gapLen", cyc, 32'd60);

        $display("[TB] watchdog timeout on req1");
        doneDelay = 0;
        spiRdata  = 16'hFFFF;
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hBEEF);
        waitGrant(who);
        checkOutput("tmo.grant", who, 32'd1);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'hBEEF);
        checkOutput("tmo.spiEn", spiEn, 32'd1);
        checkOutput("tmo.mode", spiMode, 32'd3);
        waitRsp(1, 2500, cyc);
        checkOutput("tmo.enLength", cyc, 32'd2000);
        checkOutput("tmo.rspData", rsp1Data, 32'd0);
        checkOutput("tmo.rspErr", rsp1Err, 32'd1);
        checkOutput("tmo.enDropped", spiEn, 32'd0);
        waitIdle(-1, cyc, sawRsp, sawEn);
        checkOutput("tmo.gapLen", cyc, 32'd60);

        $display("[TB] done in the last watchdog cycle");
        doneDelay = 2000;
        spiRdata  = 16'h5AA5;
        applyStimulus(1'b1, 16'h1111, 1'b0, 16'h0000);
        waitGrant(who);
        checkOutput("edge.grant", who, 32'd0);
        tick(1);
        applyStimulus(1'b0, 16'h1111, 1'b0, 16'h0000);
        waitRsp(0, 2500, cyc);
        checkOutput("edge.latency", cyc, 32'd2000);
        checkOutput("edge.rspErr", rsp0Err, 32'd0);
        checkOutput("edge.rspData", rsp0Data, 32'h5AA5);
        waitIdle(-1, cyc, sawRsp, sawEn);

        $display("[TB] reset in the middle of a frame");
        doneDelay = 0;
        applyStimulus(1'b1, 16'h2222, 1'b0, 16'h0000);
        waitGrant(who);
        tick(1);
        applyStimulus(1'b0, 16'h2222, 1'b0, 16'h0000);
        tick(50);
        checkOutput("midRst.busyBefore", busy, 32'd1);
        rstN = 1'b0;
        #2;
        checkOutput("midRst.spiEn", spiEn, 32'd0);
        checkOutput("midRst.busy", busy, 32'd0);
        tick(1);
        checkOutput("midRst.noRsp", {rsp1Valid, rsp0Valid}, 32'd0);
        doneDelay = 20;
        spiRdata  = 16'h0F0F;
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h7E57);
        tick(1);
        rstN = 1'b1;
        waitGrant(who);
        checkOutput("midRst.grant", who, 32'd1);
        tick(1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h7E57);
        checkOutput("midRst.mode", spiMode, 32'd3);
        checkOutput("midRst.sdata", spiSdata, 32'h7E57);
        waitRsp(1, 100, cyc);
        checkOutput("midRst.latency", cyc, 32'd20);
        checkOutput("midRst.rspData", rsp1Data, 32'h0F0F);
        checkOutput("midRst.rspErr", rsp1Err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
